// File: rtl/ternary_neuron_acc.sv
// Ternary neuron accumulator: sums signed per-chunk popcount deltas and thresholds to {+1,0,-1}.
// Optional feature macro: TNN_ACC_SAT_EN (saturating accumulator with sticky out_sat flag).
module ternary_neuron_acc #(
   parameter int NUM_BEATS = 4,
   parameter int ACC_W     = 8,
   parameter int TH_HI     = 3,
   parameter int TH_LO     = -3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_pos,
   input  logic [3:0]       in_neg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_act,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_sat
);

   localparam int CW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_BEATS - 1);
   localparam logic signed [ACC_W-1:0] HI = ACC_W'(TH_HI);
   localparam logic signed [ACC_W-1:0] LO = ACC_W'(TH_LO);

   if (TH_LO >= TH_HI) begin : g_th_chk
      $error("ternary_neuron_acc: TH_LO must be below TH_HI");
   end
   if (NUM_BEATS < 1) begin : g_nb_chk
      $error("ternary_neuron_acc: NUM_BEATS must be at least 1");
   end
   if (ACC_W < 5) begin : g_w_chk
      $error("ternary_neuron_acc: ACC_W must be at least 5");
   end

   typedef enum logic {S_ACC, S_OUT} state_t;

   state_t                  state;
   logic signed [ACC_W-1:0] acc;
   logic [CW-1:0]           cnt;
   logic [4:0]              delta;
   logic signed [ACC_W:0]   wide;
   logic signed [ACC_W-1:0] nxt;
   logic                    nxt_sat;

   assign delta = {1'b0, in_pos} - {1'b0, in_neg};
   // One guard bit exposes overflow of the ACC_W-bit sum
   assign wide  = {acc[ACC_W-1], acc} + {{(ACC_W-4){delta[4]}}, delta};

`ifdef TNN_ACC_SAT_EN
   logic ovf;
   logic sat_q;

   assign ovf = wide[ACC_W] ^ wide[ACC_W-1];

   always_comb begin
      nxt = wide[ACC_W-1:0];
      if (ovf)
         nxt = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
   end
   assign nxt_sat = sat_q | ovf;
`else
   assign nxt     = wide[ACC_W-1:0];
   assign nxt_sat = 1'b0;
`endif

   function automatic logic [1:0] act_of(input logic signed [ACC_W-1:0] s);
      if (s >= HI)      return 2'b01;
      else if (s <= LO) return 2'b11;
      else              return 2'b00;
   endfunction

   assign in_ready  = (state == S_ACC);
   assign out_valid = (state == S_OUT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_ACC;
         acc     <= '0;
         cnt     <= '0;
         out_act <= 2'b00;
         out_sum <= '0;
         out_sat <= 1'b0;
`ifdef TNN_ACC_SAT_EN
         sat_q   <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_ACC: begin
               if (in_valid) begin
                  acc <= nxt;
`ifdef TNN_ACC_SAT_EN
                  sat_q <= nxt_sat;
`endif
                  if (cnt == LAST) begin
                     out_sum <= nxt;
                     out_act <= act_of(nxt);
                     out_sat <= nxt_sat;
                     state   <= S_OUT;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  acc     <= '0;
                  cnt     <= '0;
                  out_sat <= 1'b0;
`ifdef TNN_ACC_SAT_EN
                  sat_q   <= 1'b0;
`endif
                  state   <= S_ACC;
               end
            end
            default: state <= S_ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Bench for ternary_neuron_acc: directed scenarios plus random neurons vs an integer model.
// Two instances: default widths (dut 0) and ACC_W=5 (dut 1).
module tb_ternary_neuron_acc;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vld  [2];
   logic       ir   [2];
   logic [3:0] ipos [2];
   logic [3:0] ineg [2];
   logic       ov   [2];
   logic       ordy [2];
   logic [1:0] oact [2];
   logic       osat [2];
   logic [7:0] sum_a;
   logic [4:0] sum_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ternary_neuron_acc u_a (
      .clk(clk), .rst(rst),
      .in_valid(vld[0]), .in_ready(ir[0]),
      .in_pos(ipos[0]), .in_neg(ineg[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]),
      .out_act(oact[0]), .out_sum(sum_a), .out_sat(osat[0])
   );

   ternary_neuron_acc #(.ACC_W(5)) u_b (
      .clk(clk), .rst(rst),
      .in_valid(vld[1]), .in_ready(ir[1]),
      .in_pos(ipos[1]), .in_neg(ineg[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]),
      .out_act(oact[1]), .out_sum(sum_b), .out_sat(osat[1])
   );

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int sum_of(input int d);
      return (d == 0) ? int'($signed(sum_a)) : int'($signed(sum_b));
   endfunction

   function automatic int exp_act(input int s);
      if (s >= 3)       return 1;
      else if (s <= -3) return 3;
      else              return 0;
   endfunction

   // Reference: plain integer running sum, then clamp or wrap into the signed range
   task automatic model(input int w, input int ps[4], input int ns[4],
                        output int s, output int sat);
      int lo, hi, m;
      m  = 1 << w;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      s = 0;
      sat = 0;
      for (int i = 0; i < 4; i++) begin
         s += ps[i] - ns[i];
`ifdef TNN_ACC_SAT_EN
         if (s > hi) begin s = hi; sat = 1; end
         else if (s < lo) begin s = lo; sat = 1; end
`else
         if (s > hi) s -= m;
         else if (s < lo) s += m;
`endif
      end
   endtask

   task automatic beat(input int d, input int p, input int n);
      int k;
      k = 0;
      vld[d] = 1'b1;
      ipos[d] = 4'(p);
      ineg[d] = 4'(n);
      while (ir[d] !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("beat_ready", int'(ir[d]), 1);
      @(negedge clk);
      vld[d] = 1'b0;
   endtask

   task automatic run_neuron(input int d, input int ps[4], input int ns[4],
                             input int bub, input int hold,
                             output int got_sum, output int got_act);
      int es, esat, nb;
      model((d == 0) ? 8 : 5, ps, ns, es, esat);
      for (int i = 0; i < 4; i++) begin
         nb = (bub >= 0) ? bub : int'($urandom_range(0, 3));
         repeat (nb) @(negedge clk);
         beat(d, ps[i], ns[i]);
      end
      chk("lat_valid", int'(ov[d]), 1);
      got_sum = sum_of(d);
      got_act = int'(oact[d]);
      chk("sum", got_sum, es);
      chk("act", got_act, exp_act(es));
      chk("sat", int'(osat[d]), esat);
      for (int h = 0; h < hold; h++) begin
         vld[d] = 1'b1;
         ipos[d] = 4'($urandom);
         ineg[d] = 4'($urandom);
         @(negedge clk);
         chk("hold_ready", int'(ir[d]), 0);
         chk("hold_valid", int'(ov[d]), 1);
         chk("hold_sum", sum_of(d), es);
      end
      ordy[d] = 1'b1;
      @(negedge clk);
      ordy[d] = 1'b0;
      vld[d] = 1'b0;
      chk("post_valid", int'(ov[d]), 0);
      chk("post_ready", int'(ir[d]), 1);
      chk("post_sum", sum_of(d), es);
      chk("post_act", int'(oact[d]), exp_act(es));
      chk("post_sat", int'(osat[d]), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int p4[4], n4[4], gs, ga;
      for (int d = 0; d < 2; d++) begin
         vld[d] = 1'b0; ipos[d] = '0; ineg[d] = '0; ordy[d] = 1'b0;
      end

      // T1 reset
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_valid", int'(ov[d]), 0);
         chk("rst_act", int'(oact[d]), 0);
         chk("rst_sum", sum_of(d), 0);
         chk("rst_sat", int'(osat[d]), 0);
         chk("rst_ready", int'(ir[d]), 1);
      end
      rst = 1'b0;

      // T2 back-to-back
      p4 = '{5, 3, 1, 0}; n4 = '{2, 3, 0, 1};
      run_neuron(0, p4, n4, 0, 0, gs, ga);
      chk("t2_sum", gs, 3);
      chk("t2_act", ga, 1);

      // T3 bubbles
      p4 = '{0, 0, 0, 0}; n4 = '{4, 4, 4, 4};
      run_neuron(0, p4, n4, 2, 0, gs, ga);
      chk("t3_sum", gs, -16);
      chk("t3_act", ga, 3);

      // T4 backpressure then next neuron
      p4 = '{2, 0, 1, 0}; n4 = '{1, 0, 1, 0};
      run_neuron(0, p4, n4, 0, 5, gs, ga);
      chk("t4a_sum", gs, 1);
      chk("t4a_act", ga, 0);
      p4 = '{1, 1, 1, 1}; n4 = '{0, 0, 0, 0};
      run_neuron(0, p4, n4, 0, 0, gs, ga);
      chk("t4b_sum", gs, 4);
      chk("t4b_act", ga, 1);

      // T5 reset mid-neuron
      beat(0, 9, 0);
      beat(0, 9, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_ready", int'(ir[0]), 1);
      p4 = '{0, 0, 0, 0}; n4 = '{1, 1, 1, 1};
      run_neuron(0, p4, n4, 0, 0, gs, ga);
      chk("t5_sum", gs, -4);
      chk("t5_act", ga, 3);

      // T6 narrow accumulator overflow
      p4 = '{15, 15, 15, 15}; n4 = '{0, 0, 0, 0};
      run_neuron(1, p4, n4, 0, 0, gs, ga);
`ifdef TNN_ACC_SAT_EN
      chk("t6_sum", gs, 15);
      chk("t6_act", ga, 1);
`else
      chk("t6_sum", gs, -4);
      chk("t6_act", ga, 3);
`endif

      // Random neurons on both instances
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < 4; i++) begin
            p4[i] = int'($urandom_range(0, 15));
            n4[i] = int'($urandom_range(0, 15));
         end
         run_neuron(r % 2, p4, n4, -1, int'($urandom_range(0, 3)), gs, ga);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
